// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state
// encodings, default width and the iteration counter sizing helper.
package mult_div_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_e;

  // Counter must hold the value WIDTH itself, hence the extra bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

  localparam int unsigned CNT_W_DEFAULT = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/mult_div_signfix.sv
// Conditional two's-complement negation: two WIDTH-bit lanes and one
// 2*WIDTH-bit lane. Used for operand magnitudes at accept and for result
// sign correction in FIX.
module mult_div_signfix
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic               i_neg_a,
  output logic [WIDTH-1:0]   o_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic               i_neg_b,
  output logic [WIDTH-1:0]   o_b,
  input  logic [2*WIDTH-1:0] i_p,
  input  logic               i_neg_p,
  output logic [2*WIDTH-1:0] o_p
);

  // Unary minus on an unsigned vector wraps, so -2^(W-1) maps to itself.
  always_comb begin
    o_a = i_neg_a ? -i_a : i_a;
    o_b = i_neg_b ? -i_b : i_b;
    o_p = i_neg_p ? -i_p : i_p;
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with private HI/LO registers.
// MULT/MULTU use shift-add over a 2*WIDTH accumulator, DIV/DIVU use
// restoring division; sign handling is done on magnitudes at accept and
// corrected in FIX. Optional macro MULTDIV_EARLY_TERM_EN ends a multiply as
// soon as the remaining multiplier bits are all zero.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  input  logic             i_advance,
  input  logic             i_mthi,
  input  logic             i_mtlo,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_div_zero
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e               r_state;
  state_e               w_state_next;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_div_zero;
  // Multiplier (shifted right each MUL step) or divisor (constant in DIV).
  logic [WIDTH-1:0]     r_b;
  // MUL: running product. DIV: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [CntW-1:0]      r_cnt;
  logic                 r_neg_ab;
  logic                 r_neg_r;
  logic                 r_is_div;

  op_e                  w_op;
  logic                 w_signed;
  logic                 w_is_div;
  logic                 w_accept;
  logic                 w_mt_ok;
  logic                 w_dz;
  logic                 w_last_iter;
  logic                 w_mul_done;
  logic                 w_busy;
  logic [WIDTH-1:0]     w_mul_b_next;
  logic [WIDTH:0]       w_trial;

  logic [WIDTH-1:0]     w_fix_a_in;
  logic                 w_fix_a_neg;
  logic [WIDTH-1:0]     w_fix_a_out;
  logic [WIDTH-1:0]     w_fix_b_in;
  logic                 w_fix_b_neg;
  logic [WIDTH-1:0]     w_fix_b_out;
  logic [2*WIDTH-1:0]   w_fix_p_out;

  assign w_op     = op_e'(i_op);
  assign w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
  assign w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU);
  assign w_accept = (r_state == ST_IDLE) && i_start;
  // MTHI/MTLO only land while the unit is quiescent and no op is issuing.
  assign w_mt_ok  = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && !i_start;
  assign w_dz     = r_is_div && (r_b == '0);

  assign w_last_iter  = (r_cnt == CntW'(1));
  assign w_mul_b_next = r_b >> 1;
`ifdef MULTDIV_EARLY_TERM_EN
  assign w_mul_done   = w_last_iter || (w_mul_b_next == '0);
`else
  assign w_mul_done   = w_last_iter;
`endif

  // Trial subtract of divisor from {remainder, next dividend bit}; bit WIDTH is the borrow.
  assign w_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_b};

  // Share one negator: operands at accept, results in FIX.
  always_comb begin
    w_fix_a_in  = i_src_a;
    w_fix_a_neg = w_signed && i_src_a[WIDTH-1];
    w_fix_b_in  = i_src_b;
    w_fix_b_neg = w_signed && i_src_b[WIDTH-1];
    if (r_state == ST_FIX) begin
      // On divide-by-zero the dividend magnitude re-signed gives back src_a for HI.
      w_fix_a_in  = w_dz ? r_acc[WIDTH-1:0] : r_acc[2*WIDTH-1:WIDTH];
      w_fix_a_neg = r_neg_r;
      w_fix_b_in  = r_acc[WIDTH-1:0];
      w_fix_b_neg = r_neg_ab;
    end
  end

  mult_div_signfix #(
    .WIDTH (WIDTH)
  ) u_signfix (
    .i_a     (w_fix_a_in),
    .i_neg_a (w_fix_a_neg),
    .o_a     (w_fix_a_out),
    .i_b     (w_fix_b_in),
    .i_neg_b (w_fix_b_neg),
    .o_b     (w_fix_b_out),
    .i_p     (r_acc),
    .i_neg_p (r_neg_ab),
    .o_p     (w_fix_p_out)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and stall request.
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // Combinational so the issuing instruction stalls in its first EX cycle.
        w_busy = i_start;
        if (i_start) begin
          if (w_is_div) begin
            w_state_next = (i_src_b == '0) ? ST_FIX : ST_DIV;
          end else begin
`ifdef MULTDIV_EARLY_TERM_EN
            w_state_next = (i_src_b == '0) ? ST_FIX : ST_MUL;
`else
            w_state_next = ST_MUL;
`endif
          end
        end
      end
      ST_MUL: begin
        w_busy = 1'b1;
        if (w_mul_done) w_state_next = ST_FIX;
      end
      ST_DIV: begin
        w_busy = 1'b1;
        if (w_last_iter) w_state_next = ST_FIX;
      end
      ST_FIX: begin
        w_busy       = 1'b1;
        w_state_next = ST_DONE;
      end
      ST_DONE: begin
        // start is ignored here so the same instruction cannot issue twice.
        if (i_advance) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: accept, per-cycle iteration, result write and MTHI/MTLO.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_div_zero <= 1'b0;
      r_b        <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_cnt      <= '0;
      r_neg_ab   <= 1'b0;
      r_neg_r    <= 1'b0;
      r_is_div   <= 1'b0;
    end else if (w_accept) begin
      r_is_div   <= w_is_div;
      r_neg_ab   <= w_signed && (i_src_a[WIDTH-1] ^ i_src_b[WIDTH-1]);
      r_neg_r    <= w_signed && i_src_a[WIDTH-1];
      r_div_zero <= 1'b0;
      r_cnt      <= CntW'(WIDTH);
      r_b        <= w_fix_b_out;
      r_mcand    <= {{WIDTH{1'b0}}, w_fix_a_out};
      r_acc      <= w_is_div ? {{WIDTH{1'b0}}, w_fix_a_out} : '0;
    end else if (r_state == ST_MUL) begin
      r_acc   <= r_acc + (r_b[0] ? r_mcand : '0);
      r_mcand <= r_mcand << 1;
      r_b     <= w_mul_b_next;
      r_cnt   <= r_cnt - CntW'(1);
    end else if (r_state == ST_DIV) begin
      if (!w_trial[WIDTH]) begin
        r_acc <= {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      end else begin
        r_acc <= {r_acc[2*WIDTH-2:0], 1'b0};
      end
      r_cnt <= r_cnt - CntW'(1);
    end else if (r_state == ST_FIX) begin
      if (w_dz) begin
        r_hi       <= w_fix_a_out;
        r_lo       <= '1;
        r_div_zero <= 1'b1;
      end else if (r_is_div) begin
        r_hi <= w_fix_a_out;
        r_lo <= w_fix_b_out;
      end else begin
        r_hi <= w_fix_p_out[2*WIDTH-1:WIDTH];
        r_lo <= w_fix_p_out[WIDTH-1:0];
      end
    end else if (w_mt_ok) begin
      if (i_mthi) r_hi <= i_wdata;
      if (i_mtlo) r_lo <= i_wdata;
    end
  end

  assign o_busy     = w_busy;
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;
  assign o_div_zero = r_div_zero;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops
// compared against an arithmetic reference model. Honours
// MULTDIV_EARLY_TERM_EN for the expected stall length.
module tb_mult_div_unit;
  import mult_div_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_advance, i_mthi, i_mtlo;
  logic [1:0]  i_op;
  logic [31:0] i_src_a, i_src_b, i_wdata;
  logic        o_busy, o_div_zero;
  logic [31:0] o_hi, o_lo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mult_div_unit #(
    .WIDTH (32)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_op       (i_op),
    .i_src_a    (i_src_a),
    .i_src_b    (i_src_b),
    .i_advance  (i_advance),
    .i_mthi     (i_mthi),
    .i_mtlo     (i_mtlo),
    .i_wdata    (i_wdata),
    .o_busy     (o_busy),
    .o_hi       (o_hi),
    .o_lo       (o_lo),
    .o_div_zero (o_div_zero)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, truncating division.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output logic dz, output int cyc);
    longint      sa, sb, q, r, p;
    logic [31:0] mb;
    int          top;
    sa  = op[0] ? longint'({32'b0, a}) : longint'($signed(a));
    sb  = op[0] ? longint'({32'b0, b}) : longint'($signed(b));
    dz  = 1'b0;
    cyc = 34;
    if (op[1]) begin
      if (b == 32'h0) begin
        hi  = a;
        lo  = 32'hFFFF_FFFF;
        dz  = 1'b1;
        cyc = 2;
      end else begin
        q  = sa / sb;
        r  = sa % sb;
        lo = q[31:0];
        hi = r[31:0];
      end
    end else begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
`ifdef MULTDIV_EARLY_TERM_EN
      mb  = (sb < 0) ? 32'(-sb) : 32'(sb);
      top = -1;
      for (int i = 0; i < 32; i++) if (mb[i]) top = i;
      cyc = 2 + top + 1;
`else
      mb  = 32'h0;
      top = 0;
`endif
    end
  endfunction

  // Issue one op, count stall cycles, check result, optionally hold in DONE.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input logic mt);
    logic [31:0] ehi, elo;
    logic        edz;
    int          ecyc, n;
    model(op, a, b, ehi, elo, edz, ecyc);
    @(negedge clk);
    i_start   = 1'b1;
    i_op      = op;
    i_src_a   = a;
    i_src_b   = b;
    i_advance = 1'b0;
    i_mthi    = mt;
    i_mtlo    = mt;
    i_wdata   = 32'hDEAD_BEEF;
    #1;
    n = 0;
    while (o_busy && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    check_eq("busy_cycles", 64'(n), 64'(ecyc));
    check_eq("hi", o_hi, ehi);
    check_eq("lo", o_lo, elo);
    check_eq("div_zero", o_div_zero, edz);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      #1;
      check_eq("done_hold_busy", o_busy, 0);
      check_eq("done_hold_lo", o_lo, elo);
    end
    @(negedge clk);
    i_advance = 1'b1;
    @(negedge clk);
    i_start   = 1'b0;
    i_advance = 1'b0;
    i_mthi    = 1'b0;
    i_mtlo    = 1'b0;
    #1;
    check_eq("idle_busy", o_busy, 0);
    check_eq("idle_hi", o_hi, ehi);
    check_eq("idle_lo", o_lo, elo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 255));
      5:       return -32'($urandom_range(1, 255));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    i_rst     = 1'b1;
    i_start   = 1'b0;
    i_op      = 2'b00;
    i_src_a   = '0;
    i_src_b   = '0;
    i_advance = 1'b0;
    i_mthi    = 1'b0;
    i_mtlo    = 1'b0;
    i_wdata   = '0;
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    #1;
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_hi", o_hi, 0);
    check_eq("rst_lo", o_lo, 0);
    check_eq("rst_dz", o_div_zero, 0);

    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7, 3, 1'b0);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(OP_DIV,   -32'd7, 32'd2, 0, 1'b0);
    run_op(OP_DIVU,  32'd100, 32'd7, 0, 1'b0);
    run_op(OP_DIVU,  32'd5, 32'd0, 0, 1'b0);
    run_op(OP_MULT,  32'd1, 32'd1, 0, 1'b0);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(OP_MULTU, 32'h1234_5678, 32'h0000_0100, 2, 1'b1);
    run_op(OP_DIV,   32'h8000_0000, 32'd0, 0, 1'b0);

    // Reset in the middle of a divide discards everything.
    @(negedge clk);
    i_start = 1'b1;
    i_op    = OP_DIV;
    i_src_a = 32'd1000;
    i_src_b = 32'd3;
    #1;
    check_eq("div_accept_busy", o_busy, 1);
    repeat (10) @(negedge clk);
    #1;
    check_eq("div_mid_busy", o_busy, 1);
    i_rst   = 1'b1;
    i_start = 1'b0;
    @(negedge clk);
    i_rst = 1'b0;
    #1;
    check_eq("midrst_busy", o_busy, 0);
    check_eq("midrst_hi", o_hi, 0);
    check_eq("midrst_lo", o_lo, 0);
    check_eq("midrst_dz", o_div_zero, 0);

    // MTLO / MTHI in IDLE.
    i_mtlo  = 1'b1;
    i_wdata = 32'h0000_1234;
    @(negedge clk);
    i_mtlo = 1'b0;
    #1;
    check_eq("mtlo_lo", o_lo, 32'h1234);
    check_eq("mtlo_hi", o_hi, 0);
    i_mthi  = 1'b1;
    i_wdata = 32'hABCD_0001;
    @(negedge clk);
    i_mthi = 1'b0;
    #1;
    check_eq("mthi_hi", o_hi, 32'hABCD_0001);
    check_eq("mthi_lo", o_lo, 32'h1234);

    for (int t = 0; t < 60; t++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), int'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the EX stage of the pipelined MIPS core.
- Executes MULT/MULTU/DIV/DIVU into private HI/LO registers and supplies HI/LO to MFHI/MFLO.
- Drives the ALU stall request into the stall aggregator, which freezes IF/ID/EX and bubbles EX while the unit works.
- One bit per cycle (radix-2); no pipelining of back-to-back ops.

Parameters:
WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  level; EX holds a mult/div instruction (ctrl-qualified, not bubbled)
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
src_a  in  WIDTH  rs value (multiplicand / dividend)
src_b  in  WIDTH  rt value (multiplier / divisor)
advance  in  1  EX register will load next instruction this cycle (= !stall_EX)
mthi  in  1  write HI from wdata
mtlo  in  1  write LO from wdata
wdata  in  WIDTH  MTHI/MTLO data
busy  out  1  stall request to stall aggregator (stall_alu)
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
div_zero  out  1  sticky: last DIV/DIVU had divisor 0; cleared on next accepted op

Behaviour:
- Reset: state IDLE; hi, lo, div_zero = 0; busy = 0.
  - Reset wins over every other input in the same cycle, including mid-operation; any partial result is discarded.
- States:
  - IDLE: accept when start=1. busy = start (combinational) so the issuing instruction stalls in its first EX cycle.
  - MUL / DIV: WIDTH iterations, one per cycle; busy=1.
  - FIX: sign correction and HI/LO write; busy=1.
  - DONE: busy=0. Go to IDLE when advance=1; stay in DONE while advance=0 (dcache stall). start is ignored in DONE, so one instruction never issues twice.
- Accept cycle (IDLE, start=1):
  - Latch |src_a| and |src_b| for signed ops, raw values for unsigned.
  - Record the result signs: product sign = a^b; quotient sign = a^b; remainder sign = a.
  - Clear div_zero.
  - Go to MUL or DIV. A DIV/DIVU with src_b==0 goes straight to FIX.
- Multiply: shift-add over a 2*WIDTH accumulator. FIX negates the 64-bit product if the sign is set. HI = upper WIDTH bits, LO = lower WIDTH bits.
- Divide: restoring division, WIDTH-bit remainder plus a 1-bit trial subtract. FIX negates the quotient/remainder per the recorded signs. LO = quotient, HI = remainder.
- Divide by zero: HI = src_a, LO = all ones, div_zero=1.
- Latency:
  - Normal op: busy high 1 (accept) + WIDTH + 1 (FIX) = 34 consecutive cycles; hi/lo valid in DONE.
  - Divide by zero: busy high 2 cycles.
- Signed edge case: -2^31 / -1 gives LO = 0x80000000, HI = 0 (wraps, no trap).
- MTHI/MTLO:
  - Take effect only in IDLE or DONE with start=0.
  - When asserted in MUL/DIV/FIX: ignored (the pipeline is frozen, so this cannot occur legally).
  - start and mthi/mtlo asserted together: start wins.
- hi/lo hold their values in all other states; MFHI/MFLO read them directly.

Optional Feature:
MULTDIV_EARLY_TERM_EN
- Defined: in MUL, when the remaining unshifted multiplier bits are all zero, jump to FIX immediately.
  - Latency becomes 1 + (index of highest set multiplier bit + 1) + 1.
  - src_b==0 gives busy for 2 cycles.
  - Division is unchanged.
- Undefined: fixed WIDTH iterations always.
- Results are identical either way.

Decomposition:
- mult_div_pkg:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
  - state encoding (ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_DONE)
  - WIDTH default and the iteration counter width, $clog2(WIDTH)+1
- Sub-module mult_div_signfix: combinational conditional two's-complement negate for WIDTH and 2*WIDTH values, used at accept and at FIX.

Test Plan:
- MULT 0xFFFFFFFD (-3) x 7, advance=1 → busy high exactly 34 cycles; DONE: HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7 / 2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 100/7 → LO=14, HI=2.
- DIVU 5/0 → busy 2 cycles, HI=5, LO=0xFFFFFFFF, div_zero=1. Following MULT 1x1 → div_zero cleared.
- MULT completes with advance=0 for 3 cycles, start held → stays in DONE, busy=0, no re-issue. With advance=1 → IDLE, hi/lo unchanged.
- rst=1 at iteration 10 of a DIV → next cycle IDLE, busy=0, hi=lo=0. MTLO 0x1234 in IDLE → lo=0x1234 next cycle.
